// File: rtl/calc_pkg.sv
// Shared constants for the calculator result transmitter: word tags, FSM encoding, result width.
package calc_pkg;

  localparam int RES_W = 12;

  localparam logic [1:0] TAG_ADD = 2'd0;
  localparam logic [1:0] TAG_SUB = 2'd1;
  localparam logic [1:0] TAG_MUL = 2'd2;
  localparam logic [1:0] TAG_DIV = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Widen one captured result to the common word width; sub is two's complement.
  function automatic logic [RES_W-1:0] norm_word(
    input logic [1:0]  tag,
    input logic [6:0]  add,
    input logic [6:0]  sub,
    input logic [11:0] mul,
    input logic [5:0]  div
  );
    case (tag)
      TAG_ADD: return {5'b0, add};
      TAG_SUB: return {{5{sub[6]}}, sub};
      TAG_MUL: return mul;
      default: return {6'b0, div};
    endcase
  endfunction

endpackage

// File: rtl/calc_result_tx.sv
// Captures add/sub/mul/div on i_start, then sends them as four tagged 12-bit words over valid/ready,
// first word one cycle after capture, held while i_ready is low; optional o_parity under CALC_TX_PARITY_EN.
module calc_result_tx
  import calc_pkg::*;
#(
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             i_start,
  input  logic [6:0]       i_add,
  input  logic [6:0]       i_sub,
  input  logic [11:0]      i_mul,
  input  logic [5:0]       i_div,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [RES_W-1:0] o_data,
  output logic [1:0]       o_tag,
  output logic             o_busy,
`ifdef CALC_TX_PARITY_EN
  output logic             o_parity,
`endif
  output logic             o_done
);

  localparam logic [3:0] GAP_LOAD = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  logic [1:0]       state;
  logic [6:0]       add_q;
  logic [6:0]       sub_q;
  logic [11:0]      mul_q;
  logic [5:0]       div_q;
  logic [1:0]       tag_q;
  logic [3:0]       gap_cnt;
  logic [RES_W-1:0] data_q;
  logic             par_q;

  logic             accept;
  logic [1:0]       tag_nxt;
  logic             load;
  logic [RES_W-1:0] load_val;

  assign accept  = (state == ST_SEND) && i_ready;
  assign tag_nxt = tag_q + 2'd1;

  // The output word is loaded one edge ahead so it is stable for the whole SEND cycle.
  always_comb begin
    load     = 1'b0;
    load_val = data_q;
    if ((state == ST_IDLE) && i_start) begin
      load     = 1'b1;
      load_val = norm_word(TAG_ADD, i_add, i_sub, i_mul, i_div);
    end else if (accept && (tag_q != TAG_DIV)) begin
      load     = 1'b1;
      load_val = norm_word(tag_nxt, add_q, sub_q, mul_q, div_q);
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state   <= ST_IDLE;
      add_q   <= '0;
      sub_q   <= '0;
      mul_q   <= '0;
      div_q   <= '0;
      tag_q   <= TAG_ADD;
      gap_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            add_q <= i_add;
            sub_q <= i_sub;
            mul_q <= i_mul;
            div_q <= i_div;
            tag_q <= TAG_ADD;
            state <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (i_ready) begin
            if (tag_q == TAG_DIV) begin
              state <= ST_DONE;
            end else begin
              tag_q <= tag_nxt;
              if (GAP_CYCLES > 0) begin
                state   <= ST_GAP;
                gap_cnt <= GAP_LOAD;
              end
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == 4'd0) state <= ST_SEND;
          else                 gap_cnt <= gap_cnt - 4'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      data_q <= '0;
      par_q  <= 1'b0;
    end else if (load) begin
      data_q <= load_val;
      par_q  <= ^load_val;
    end
  end

  assign o_valid = (state == ST_SEND);
  assign o_data  = data_q;
  assign o_tag   = tag_q;
  assign o_busy  = (state != ST_IDLE);
  assign o_done  = (state == ST_DONE);
`ifdef CALC_TX_PARITY_EN
  assign o_parity = par_q;
`endif

endmodule

// File: tb/tb_calc_result_tx.sv
// Directed bench for calc_result_tx: GAP_CYCLES=0 and GAP_CYCLES=3 instances share stimulus and are
// compared every cycle against a transaction-level model, plus hand-computed literal expectations.
module tb_calc_result_tx;

  logic        clk = 1'b0;
  logic        rstb = 1'b0;
  logic        i_start = 1'b0;
  logic [6:0]  i_add = '0;
  logic [6:0]  i_sub = '0;
  logic [11:0] i_mul = '0;
  logic [5:0]  i_div = '0;
  logic        i_ready = 1'b1;

  logic        vld [2];
  logic [11:0] dat [2];
  logic [1:0]  tg  [2];
  logic        bsy [2];
  logic        dne [2];
`ifdef CALC_TX_PARITY_EN
  logic        par [2];
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  calc_result_tx #(.GAP_CYCLES(0)) dut0 (
    .clk(clk), .rstb(rstb), .i_start(i_start), .i_add(i_add), .i_sub(i_sub),
    .i_mul(i_mul), .i_div(i_div), .i_ready(i_ready), .o_valid(vld[0]), .o_data(dat[0]),
    .o_tag(tg[0]), .o_busy(bsy[0]),
`ifdef CALC_TX_PARITY_EN
    .o_parity(par[0]),
`endif
    .o_done(dne[0]));

  calc_result_tx #(.GAP_CYCLES(3)) dut3 (
    .clk(clk), .rstb(rstb), .i_start(i_start), .i_add(i_add), .i_sub(i_sub),
    .i_mul(i_mul), .i_div(i_div), .i_ready(i_ready), .o_valid(vld[1]), .o_data(dat[1]),
    .o_tag(tg[1]), .o_busy(bsy[1]),
`ifdef CALC_TX_PARITY_EN
    .o_parity(par[1]),
`endif
    .o_done(dne[1]));

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference behaviour: a captured list of four words drained one per acceptance,
  // with a fixed number of silent cycles after each non-final acceptance.
  int  gapv [2] = '{0, 3};
  int  m_words [2][4];
  bit  m_act [2] = '{0, 0};
  int  m_idx [2] = '{0, 0};
  int  m_gap [2] = '{0, 0};
  bit  m_done [2] = '{0, 0};

  function automatic int norm(input int t, input int a, input int s, input int m, input int d);
    int sv;
    case (t)
      0: return a;
      1: begin
        sv = (s >= 64) ? s - 128 : s;
        return sv & 'hFFF;
      end
      2: return m;
      default: return d;
    endcase
  endfunction

  always @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int g = 0; g < 2; g++) begin
        m_act[g] = 0; m_idx[g] = 0; m_gap[g] = 0; m_done[g] = 0;
      end
    end else begin
      for (int g = 0; g < 2; g++) begin
        if (m_done[g]) m_done[g] = 0;
        else if (!m_act[g]) begin
          if (i_start) begin
            for (int t = 0; t < 4; t++) m_words[g][t] = norm(t, i_add, i_sub, i_mul, i_div);
            m_act[g] = 1; m_idx[g] = 0; m_gap[g] = 0;
          end
        end else if (m_gap[g] > 0) m_gap[g]--;
        else if (i_ready) begin
          if (m_idx[g] == 3) begin m_act[g] = 0; m_done[g] = 1; end
          else begin m_idx[g]++; m_gap[g] = gapv[g]; end
        end
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Every-cycle compare against the model.
  always @(negedge clk) begin
    if (rstb) begin
      for (int g = 0; g < 2; g++) begin
        chk($sformatf("valid[%0d]", g), vld[g], (m_act[g] && m_gap[g] == 0) ? 1 : 0);
        chk($sformatf("busy[%0d]", g), bsy[g], (m_act[g] || m_done[g]) ? 1 : 0);
        chk($sformatf("done[%0d]", g), dne[g], m_done[g] ? 1 : 0);
        if (m_act[g] && m_gap[g] == 0) begin
          chk($sformatf("data[%0d]", g), dat[g], m_words[g][m_idx[g]]);
          chk($sformatf("tag[%0d]", g), tg[g], m_idx[g]);
`ifdef CALC_TX_PARITY_EN
          chk($sformatf("parity[%0d]", g), par[g], ^dat[g]);
`endif
        end
      end
    end
  end

  // Transaction log used by the literal checks.
  int d0_data[$];
  int d0_tag[$];
  int d0_cyc[$];
  int d3_cyc[$];
  int d0_done_cnt = 0, d3_done_cnt = 0, d0_done_cyc = 0, d0_busy_cnt = 0, d0_tag2_cnt = 0;

  always @(negedge clk) begin
    if (vld[0] && i_ready) begin
      d0_data.push_back(dat[0]); d0_tag.push_back(tg[0]); d0_cyc.push_back(cyc);
    end
    if (vld[1] && i_ready) d3_cyc.push_back(cyc);
    if (dne[0]) begin d0_done_cnt++; d0_done_cyc = cyc; end
    if (dne[1]) d3_done_cnt++;
    if (bsy[0]) d0_busy_cnt++;
    if (vld[0] && tg[0] == 2'd2) d0_tag2_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    d0_data.delete(); d0_tag.delete(); d0_cyc.delete(); d3_cyc.delete();
    d0_done_cnt = 0; d3_done_cnt = 0; d0_done_cyc = 0; d0_busy_cnt = 0; d0_tag2_cnt = 0;
  endtask

  task automatic start_seq(input logic [6:0] a, input logic [6:0] s, input logic [11:0] m,
                           input logic [5:0] d);
    i_add = a; i_sub = s; i_mul = m; i_div = d;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    tick();
    while ((bsy[0] || bsy[1]) && n < 300) begin tick(); n++; end
    if (n >= 300) chk("idle_timeout", 1, 0);
    tick();
  endtask

  task automatic wait_tag0(input int t);
    int n = 0;
    @(negedge clk);
    while (!(vld[0] && tg[0] == 2'(t)) && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("tag_wait_timeout", 1, 0);
  endtask

  task automatic chk_zero(input string name);
    for (int g = 0; g < 2; g++) begin
      chk({name, "_valid"}, vld[g], 0);
      chk({name, "_data"}, dat[g], 0);
      chk({name, "_tag"}, tg[g], 0);
      chk({name, "_busy"}, bsy[g], 0);
      chk({name, "_done"}, dne[g], 0);
`ifdef CALC_TX_PARITY_EN
      chk({name, "_parity"}, par[g], 0);
`endif
    end
  endtask

  int exp1 [4] = '{'h008, 'h002, 'h00F, 'h001};
  int exp2 [4] = '{'h07F, 'hFFE, 'hFFF, 'h03F};

  initial begin
    // Reset state
    i_add = 7'h55; i_sub = 7'h2A; i_mul = 12'h123; i_div = 6'h11;
    repeat (3) tick();
    chk_zero("reset");
    rstb = 1'b1;
    tick();

    // Basic sequence, ready held high
    clear_log();
    start_seq(7'd8, 7'd2, 12'd15, 6'd1);
    wait_idle();
    chk("t1_words", d0_data.size(), 4);
    for (int i = 0; i < 4 && i < d0_data.size(); i++) begin
      chk($sformatf("t1_data%0d", i), d0_data[i], exp1[i]);
      chk($sformatf("t1_tag%0d", i), d0_tag[i], i);
      if (i > 0) chk($sformatf("t1_consec%0d", i), d0_cyc[i] - d0_cyc[i-1], 1);
    end
    if (d0_cyc.size() == 4) chk("t1_done_after", d0_done_cyc - d0_cyc[3], 1);
    chk("t1_done_cnt", d0_done_cnt, 1);
    chk("t1_busy_cycles", d0_busy_cnt, 5);
    chk("t1_gap_words", d3_cyc.size(), 4);
    for (int i = 1; i < 4 && i < d3_cyc.size(); i++)
      chk($sformatf("t1_gap_spacing%0d", i), d3_cyc[i] - d3_cyc[i-1], 4);
    chk("t1_gap_done_cnt", d3_done_cnt, 1);

    // Extension corner values
    clear_log();
    start_seq(7'h7F, 7'h7E, 12'hFFF, 6'h3F);
    wait_idle();
    chk("t2_words", d0_data.size(), 4);
    for (int i = 0; i < 4 && i < d0_data.size(); i++)
      chk($sformatf("t2_data%0d", i), d0_data[i], exp2[i]);

    // Backpressure on the mul word
    clear_log();
    start_seq(7'd3, 7'd4, 12'hA5C, 6'd9);
    wait_tag0(1);
    tick();
    i_ready = 1'b0;
    repeat (5) tick();
    i_ready = 1'b1;
    wait_idle();
    chk("t3_words", d0_data.size(), 4);
    for (int i = 0; i < 4 && i < d0_tag.size(); i++) chk($sformatf("t3_tag%0d", i), d0_tag[i], i);
    if (d0_data.size() > 2) chk("t3_mul", d0_data[2], 'hA5C);
    chk("t3_tag2_cycles", d0_tag2_cnt, 6);

    // Restart and input changes during SEND are ignored
    clear_log();
    start_seq(7'd20, 7'h70, 12'h321, 6'd33);
    tick();
    start_seq(7'd1, 7'd1, 12'd1, 6'd1);
    i_add = 7'd99; i_sub = 7'd5; i_mul = 12'h777; i_div = 6'd7;
    wait_idle();
    chk("t4_words", d0_data.size(), 4);
    if (d0_data.size() == 4) begin
      chk("t4_add", d0_data[0], 20);
      chk("t4_sub", d0_data[1], 'hFF0);
      chk("t4_mul", d0_data[2], 'h321);
      chk("t4_div", d0_data[3], 33);
    end
    chk("t4_done_cnt", d0_done_cnt, 1);

    // Reset mid-transfer
    clear_log();
    start_seq(7'd10, 7'd11, 12'h0C0, 6'd12);
    wait_tag0(1);
    #1 rstb = 1'b0;
    #1 chk_zero("midreset");
    tick();
    rstb = 1'b1;
    repeat (4) tick();
    chk("t5_no_done", d0_done_cnt, 0);
    chk("t5_idle", bsy[0], 0);
    clear_log();
    start_seq(7'd6, 7'd7, 12'h0AB, 6'd5);
    wait_idle();
    chk("t5_words", d0_data.size(), 4);
    if (d0_data.size() > 0) begin
      chk("t5_first_tag", d0_tag[0], 0);
      chk("t5_first_data", d0_data[0], 6);
    end
    chk("t5_done_cnt", d0_done_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
